codec_reg_seq: RTL and testbench

CODEC_REG_SEQ -- requirements
Module: codec_reg_seq

---
 rtl/codec_reg_seq_if.sv | 30 +++
 rtl/codec_reg_seq.sv | 199 +++++++++++++++++++
 tb/tb_codec_reg_seq.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/codec_reg_seq_if.sv
// codec_reg_seq_if -- write channel between the codec register sequencer and
// the I2C byte writer.
//   wr_req   sequencer -> writer  write request, held until wr_ack
//   wr_word  sequencer -> writer  {reg[6:0], data[8:0]} of the write in progress
//   wr_ack   writer -> sequencer  writer accepted wr_word
//   wr_done  writer -> sequencer  one-cycle pulse, write finished
//   wr_err   writer -> sequencer  NACK status, valid with wr_done
interface codec_reg_seq_if;
  logic        wr_req;
  logic [15:0] wr_word;
  logic        wr_ack;
  logic        wr_done;
  logic        wr_err;

  modport master (
    output wr_req,
    output wr_word,
    input  wr_ack,
    input  wr_done,
    input  wr_err
  );

  modport slave (
    input  wr_req,
    input  wr_word,
    output wr_ack,
    output wr_done,
    output wr_err
  );
endinterface

// File: rtl/codec_reg_seq.sv
// codec_reg_seq -- power-on register sequencer for an I2C audio codec.
// After reset it waits DELAY_CYC cycles, writes INIT_DEPTH table words in
// order, then serves per-channel runtime update requests (lowest channel
// first). Each failed (NACKed) write is retried up to RETRY_MAX times, then
// skipped with a sticky error flag.
// Ports:
//   Clk, Rst     clock; asynchronous active-high reset
//   init_tbl     INIT_DEPTH packed {reg, data} words, entry 0 in bits [15:0]
//   upd_go       per-channel one-cycle update request
//   upd_word     per-channel {reg, data}, sampled with upd_go
//   bus          write channel to the I2C byte writer (master side)
//   init_done    level, all init entries handled
//   busy         high in any state other than RUN_IDLE
//   err_flag     sticky, a write exhausted its retries
//   pend         latched update requests not yet written
//
// state     | meaning
// DELAY     | counting power-up delay after reset release
// INIT_REQ  | requesting write of init entry idx
// INIT_WAIT | init write accepted, waiting for wr_done
// RUN_IDLE  | init finished, no update in flight
// UPD_REQ   | requesting write of held word for channel ch_sel
// UPD_WAIT  | update write accepted, waiting for wr_done
module codec_reg_seq #(
  parameter int INIT_DEPTH = 8,
  parameter int N_CH       = 3,
  parameter int DELAY_CYC  = 600,
  parameter int RETRY_MAX  = 2
) (
  input  logic                    Clk,
  input  logic                    Rst,
  input  logic [INIT_DEPTH*16-1:0] init_tbl,
  input  logic [N_CH-1:0]         upd_go,
  input  logic [N_CH*16-1:0]      upd_word,
  codec_reg_seq_if.master         bus,
  output logic                    init_done,
  output logic                    busy,
  output logic                    err_flag,
  output logic [N_CH-1:0]         pend
);

  localparam int IDX_W = (INIT_DEPTH > 1) ? $clog2(INIT_DEPTH) : 1;
  localparam int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1;

  typedef enum logic [2:0] {
    DELAY, INIT_REQ, INIT_WAIT, RUN_IDLE, UPD_REQ, UPD_WAIT
  } state_t;

  state_t            state, nxt;
  logic [15:0]       cnt;
  logic [IDX_W-1:0]  idx;
  logic [IDX_W-1:0]  idx_p1;
  logic [2:0]        retries;
  logic [CH_W-1:0]   ch_sel;
  logic [CH_W-1:0]   low_ch;
  logic              rearm;
  logic [15:0]       hold [N_CH];
  logic [15:0]       tbl  [INIT_DEPTH];
  logic [15:0]       upd_w [N_CH];
  logic              wr_req_q;
  logic [15:0]       wr_word_q;

  logic              load_word, sel_load, idx_inc, retry_inc, retry_clr;
  logic              set_err, set_done, upd_handled, do_retry;
  logic [15:0]       word_nxt;

  assign bus.wr_req  = wr_req_q;
  assign bus.wr_word = wr_word_q;
  assign busy        = (state != RUN_IDLE);
  assign idx_p1      = idx + IDX_W'(1);

  always_comb begin
    for (int i = 0; i < INIT_DEPTH; i++) tbl[i] = init_tbl[i*16 +: 16];
    for (int i = 0; i < N_CH; i++) upd_w[i] = upd_word[i*16 +: 16];
  end

  always_comb begin
    low_ch = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (pend[i]) low_ch = CH_W'(i);
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) state <= DELAY;
    else     state <= nxt;
  end

  always_comb begin
    nxt         = state;
    load_word   = 1'b0;
    word_nxt    = 16'h0000;
    sel_load    = 1'b0;
    idx_inc     = 1'b0;
    retry_inc   = 1'b0;
    retry_clr   = 1'b0;
    set_err     = 1'b0;
    set_done    = 1'b0;
    upd_handled = 1'b0;
    do_retry    = bus.wr_err && (retries < 3'(RETRY_MAX));
    case (state)
      DELAY: begin
        if (cnt == 16'(DELAY_CYC - 1)) begin
          nxt       = INIT_REQ;
          load_word = 1'b1;
          word_nxt  = tbl[0];
        end
      end
      INIT_REQ: if (bus.wr_ack) nxt = INIT_WAIT;
      INIT_WAIT: begin
        if (bus.wr_done) begin
          if (do_retry) begin
            // wr_word is left untouched so the same word is re-issued
            retry_inc = 1'b1;
            nxt       = INIT_REQ;
          end else begin
            retry_clr = 1'b1;
            set_err   = bus.wr_err;
            if (idx == IDX_W'(INIT_DEPTH - 1)) begin
              set_done = 1'b1;
              nxt      = RUN_IDLE;
            end else begin
              idx_inc   = 1'b1;
              load_word = 1'b1;
              word_nxt  = tbl[idx_p1];
              nxt       = INIT_REQ;
            end
          end
        end
      end
      RUN_IDLE: begin
        if (|pend) begin
          sel_load  = 1'b1;
          load_word = 1'b1;
          word_nxt  = hold[low_ch];
          nxt       = UPD_REQ;
        end
      end
      UPD_REQ: if (bus.wr_ack) nxt = UPD_WAIT;
      UPD_WAIT: begin
        if (bus.wr_done) begin
          if (do_retry) begin
            retry_inc = 1'b1;
            nxt       = UPD_REQ;
          end else begin
            retry_clr   = 1'b1;
            set_err     = bus.wr_err;
            upd_handled = 1'b1;
            nxt         = RUN_IDLE;
          end
        end
      end
      default: nxt = DELAY;
    endcase
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      cnt       <= 16'h0000;
      idx       <= '0;
      retries   <= 3'd0;
      ch_sel    <= '0;
      rearm     <= 1'b0;
      wr_req_q  <= 1'b0;
      wr_word_q <= 16'h0000;
      init_done <= 1'b0;
      err_flag  <= 1'b0;
      pend      <= '0;
      for (int i = 0; i < N_CH; i++) hold[i] <= 16'h0000;
    end else begin
      cnt      <= (state == DELAY) ? cnt + 16'd1 : 16'h0000;
      wr_req_q <= (nxt == INIT_REQ) || (nxt == UPD_REQ);
      if (load_word) wr_word_q <= word_nxt;
      if (idx_inc)   idx <= idx_p1;
      if (retry_clr)      retries <= 3'd0;
      else if (retry_inc) retries <= retries + 3'd1;
      if (set_err)  err_flag  <= 1'b1;
      if (set_done) init_done <= 1'b1;
      if (sel_load) ch_sel <= low_ch;

      // A request for the in-flight channel that arrives after its word was
      // captured must survive the completion of that write.
      if (sel_load)                                     rearm <= upd_go[low_ch];
      else if (upd_handled)                             rearm <= 1'b0;
      else if ((state == UPD_REQ || state == UPD_WAIT) && upd_go[ch_sel])
                                                        rearm <= 1'b1;

      for (int i = 0; i < N_CH; i++) begin
        if (upd_go[i]) begin
          pend[i] <= 1'b1;
          hold[i] <= upd_w[i];
        end else if (upd_handled && (ch_sel == CH_W'(i)) && !rearm) begin
          pend[i] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_codec_reg_seq.sv
// tb_codec_reg_seq -- directed self-checking bench for codec_reg_seq with a
// simple behavioural I2C writer (ack and done a few cycles after request,
// optional NACKs on a chosen word).
module tb_codec_reg_seq;
  logic          Clk = 1'b0;
  logic          Rst = 1'b1;
  logic [127:0]  init_tbl;
  logic [2:0]    upd_go = 3'b000;
  logic [47:0]   upd_word = 48'h0;
  logic          init_done, busy, err_flag;
  logic [2:0]    pend;

  codec_reg_seq_if bus();

  codec_reg_seq dut (
    .Clk       (Clk),
    .Rst       (Rst),
    .init_tbl  (init_tbl),
    .upd_go    (upd_go),
    .upd_word  (upd_word),
    .bus       (bus),
    .init_done (init_done),
    .busy      (busy),
    .err_flag  (err_flag),
    .pend      (pend)
  );

  always #5 Clk = ~Clk;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [15:0] wlog [$];
  logic [15:0] nack_word = 16'h0;
  int          nack_left = 0;

  function automatic logic [15:0] tw(input int k);
    return {7'(k + 16), 9'(64 + 5 * k)};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_log(input string tag, input logic [15:0] exp_q [$]);
    logic [31:0] got;
    check({tag, "_count"}, wlog.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      got = (i < wlog.size()) ? {16'h0, wlog[i]} : 32'hDEADBEEF;
      check($sformatf("%s_w%0d", tag, i), got, {16'h0, exp_q[i]});
    end
  endtask

  // Behavioural byte writer.
  initial begin
    logic [15:0] cur;
    bus.wr_ack  = 1'b0;
    bus.wr_done = 1'b0;
    bus.wr_err  = 1'b0;
    forever begin
      @(posedge Clk); #1;
      if (bus.wr_req) begin
        repeat (2) @(posedge Clk);
        #1 bus.wr_ack = 1'b1;
        cur = bus.wr_word;
        wlog.push_back(cur);
        @(posedge Clk); #1 bus.wr_ack = 1'b0;
        repeat (2) @(posedge Clk);
        #1 bus.wr_done = 1'b1;
        bus.wr_err = (cur == nack_word) && (nack_left > 0);
        if (bus.wr_err) nack_left--;
        @(posedge Clk); #1 bus.wr_done = 1'b0;
        bus.wr_err = 1'b0;
      end
    end
  end

  task automatic do_reset(input logic [15:0] nw, input int nl);
    @(negedge Clk);
    Rst = 1'b1;
    nack_word = nw;
    nack_left = nl;
    repeat (3) @(negedge Clk);
    wlog.delete();
  endtask

  // Releases reset and counts cycles to the first write request.
  task automatic release_and_time(input string tag);
    int n = 0;
    Rst = 1'b0;
    while (!bus.wr_req && n < 2000) begin
      @(posedge Clk);
      n++;
      @(negedge Clk);
    end
    check({tag, "_delay"}, n, 600);
    check({tag, "_first_word"}, bus.wr_word, tw(0));
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (!(init_done && !busy && pend == 3'b000) && n < 600) begin
      @(negedge Clk);
      n++;
    end
    check({tag, "_init_done"}, init_done, 1);
    check({tag, "_busy"}, busy, 0);
  endtask

  task automatic pulse_upd(input logic [2:0] go, input logic [47:0] w);
    @(negedge Clk);
    upd_go   = go;
    upd_word = w;
    @(negedge Clk);
    upd_go   = 3'b000;
  endtask

  initial begin
    logic [15:0] exp_q [$];
    int n;
    for (int k = 0; k < 8; k++) init_tbl[k*16 +: 16] = tw(k);

    // Reset values and plain init sequence
    repeat (3) @(negedge Clk);
    check("rst_wr_req", bus.wr_req, 0);
    check("rst_wr_word", bus.wr_word, 0);
    check("rst_init_done", init_done, 0);
    check("rst_err_flag", err_flag, 0);
    check("rst_pend", pend, 0);
    check("rst_busy", busy, 1);
    wlog.delete();
    release_and_time("plain");
    wait_idle("plain");
    exp_q = {};
    for (int k = 0; k < 8; k++) exp_q.push_back(tw(k));
    check_log("plain", exp_q);
    check("plain_err", err_flag, 0);

    // Entry 2 NACKed three times: retries exhausted, entry skipped
    do_reset(tw(2), 3);
    release_and_time("nack3");
    wait_idle("nack3");
    exp_q = {tw(0), tw(1), tw(2), tw(2), tw(2)};
    for (int k = 3; k < 8; k++) exp_q.push_back(tw(k));
    check_log("nack3", exp_q);
    check("nack3_err", err_flag, 1);

    // Entry 2 NACKed once: recovered on retry
    do_reset(tw(2), 1);
    release_and_time("nack1");
    wait_idle("nack1");
    exp_q = {tw(0), tw(1), tw(2), tw(2)};
    for (int k = 3; k < 8; k++) exp_q.push_back(tw(k));
    check_log("nack1", exp_q);
    check("nack1_err", err_flag, 0);

    // Channels 0 and 2 requested during init, served after, in order
    do_reset(16'h0, 0);
    release_and_time("upd");
    pulse_upd(3'b101, {16'h2C22, 16'h2B33, 16'h2A11});
    @(negedge Clk);
    check("upd_pend", pend, 3'b101);
    check("upd_not_done", init_done, 0);
    wait_idle("upd");
    exp_q = {};
    for (int k = 0; k < 8; k++) exp_q.push_back(tw(k));
    exp_q.push_back(16'h2A11);
    exp_q.push_back(16'h2C22);
    check_log("upd", exp_q);
    check("upd_pend_clr", pend, 0);

    // Channel 1 requested twice while pending: last word wins, one write
    do_reset(16'h0, 0);
    release_and_time("ovr");
    pulse_upd(3'b010, {16'h0, 16'h1A05, 16'h0});
    pulse_upd(3'b010, {16'h0, 16'h1A07, 16'h0});
    check("ovr_pend", pend, 3'b010);
    wait_idle("ovr");
    exp_q = {};
    for (int k = 0; k < 8; k++) exp_q.push_back(tw(k));
    exp_q.push_back(16'h1A07);
    check_log("ovr", exp_q);

    // Reset mid-write in INIT_WAIT at idx 4 (entry 1 exhausts retries first)
    do_reset(tw(1), 3);
    release_and_time("mid");
    pulse_upd(3'b001, {16'h0, 16'h0, 16'h3F01});
    n = 0;
    while (wlog.size() < 7 && n < 400) begin
      @(negedge Clk);
      n++;
    end
    check("mid_reached_idx4", wlog.size(), 7);
    check("mid_pre_err", err_flag, 1);
    check("mid_pre_pend", pend, 3'b001);
    check("mid_pre_word", bus.wr_word, tw(4));
    @(posedge Clk);
    #2 Rst = 1'b1;
    #1;
    check("mid_wr_req", bus.wr_req, 0);
    check("mid_wr_word", bus.wr_word, 0);
    check("mid_err", err_flag, 0);
    check("mid_pend", pend, 0);
    check("mid_init_done", init_done, 0);
    check("mid_busy", busy, 1);
    repeat (3) @(negedge Clk);
    wlog.delete();
    release_and_time("mid_rerun");
    wait_idle("mid_rerun");
    exp_q = {};
    for (int k = 0; k < 8; k++) exp_q.push_back(tw(k));
    check_log("mid_rerun", exp_q);
    check("mid_rerun_err", err_flag, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
